// File: rtl/snes_pad_reader.sv
// snes_pad_reader: polls NUM_PADS serial SNES/NES pads and commits active-high button vectors per frame.
// Optional SNES_PAD_FILTER_EN: a pad's vector commits only when two consecutive frames agree.
module snes_pad_reader #(
  parameter int NUM_PADS     = 1,
  parameter int NUM_BITS     = 12,
  parameter int HALF_PERIOD  = 13,
  parameter int LATCH_HALVES = 4,
  parameter int POLL_PERIOD  = 69905
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [NUM_PADS-1:0]          joy_data,
  output logic                         joy_strobe,
  output logic                         joy_clock,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic                         valid,
  output logic                         busy
);
  localparam int PW = $clog2(POLL_PERIOD);
  localparam int HW = $clog2(HALF_PERIOD);
  localparam int LW = $clog2(LATCH_HALVES + 1);
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam int VW = NUM_PADS * NUM_BITS;
  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;
  state_t r_state, w_next;
  logic [NUM_PADS-1:0] r_sync1, r_sync2;
  logic [PW-1:0] r_poll;
  logic [HW-1:0] r_hc;
  logic [LW-1:0] r_lh;
  logic [BW-1:0] r_bit;
  logic [VW-1:0] r_shift, r_buttons, w_commit;
  logic r_pend, r_strobe, r_clock, r_valid;
  logic w_wrap, w_hc_last, w_start;
  assign w_wrap    = r_poll == PW'(POLL_PERIOD - 1);
  assign w_hc_last = r_hc == HW'(HALF_PERIOD - 1);
  assign w_start   = r_state == IDLE && r_pend && en;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? LATCH : IDLE;
      LATCH:   w_next = (w_hc_last && r_lh == LW'(LATCH_HALVES - 1)) ? LOW : LATCH;
      LOW:     w_next = w_hc_last ? HIGH : LOW;
      HIGH:    w_next = !w_hc_last ? HIGH : (r_bit == BW'(NUM_BITS - 1)) ? DONE : LOW;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // Pad lines are outputs of next state so they stay aligned with r_state and glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_poll    <= '0;
      r_pend    <= 1'b1;
      r_hc      <= '0;
      r_lh      <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_buttons <= '0;
      r_strobe  <= 1'b0;
      r_clock   <= 1'b1;
      r_valid   <= 1'b0;
    end else begin
      r_sync1  <= joy_data;
      r_sync2  <= r_sync1;
      r_poll   <= w_wrap ? '0 : r_poll + PW'(1);
      r_pend   <= w_wrap | (r_pend & ~w_start);
      r_hc     <= (r_state == IDLE || r_state == DONE || w_hc_last) ? '0 : r_hc + HW'(1);
      r_lh     <= (r_state == LATCH && w_hc_last) ? r_lh + LW'(1) : (r_state == IDLE) ? '0 : r_lh;
      r_bit    <= (r_state == HIGH && w_hc_last) ? r_bit + BW'(1) : (r_state == IDLE) ? '0 : r_bit;
      r_strobe <= w_next == LATCH;
      r_clock  <= w_next != LOW;
      r_valid  <= w_next == DONE;
      if (r_state == LOW && w_hc_last)
        for (int p = 0; p < NUM_PADS; p++) r_shift[p*NUM_BITS + int'(r_bit)] <= ~r_sync2[p];
      if (w_next == DONE) r_buttons <= w_commit;
    end
  end
`ifdef SNES_PAD_FILTER_EN
  logic [VW-1:0] r_prev;
  always_comb begin
    w_commit = r_buttons;
    for (int p = 0; p < NUM_PADS; p++)
      if (r_shift[p*NUM_BITS +: NUM_BITS] == r_prev[p*NUM_BITS +: NUM_BITS])
        w_commit[p*NUM_BITS +: NUM_BITS] = r_shift[p*NUM_BITS +: NUM_BITS];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_prev <= '0;
    else if (w_next == DONE) r_prev <= r_shift;
  end
`else
  assign w_commit = r_shift;
`endif
  assign joy_strobe = r_strobe;
  assign joy_clock  = r_clock;
  assign buttons    = r_buttons;
  assign valid      = r_valid;
  assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_snes_pad_reader.sv
// tb_snes_pad_reader: directed checks of frame timing, decode, back-to-back polling, reset and enable.
module tb_snes_pad_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic rst_a = 1'b1, en_a = 1'b0, rst_b = 1'b1, en_b = 1'b0;
  logic [1:0] data_a;
  logic [0:0] data_b;
  logic js_a, jc_a, val_a, busy_a, js_b, jc_b, val_b, busy_b;
  logic [15:0] btn_a;
  logic [11:0] btn_b;
  logic [7:0] pat0 = 8'h81, pat1 = 8'h3C, sr0 = '0, sr1 = '0;
  logic [11:0] pat_b = 12'h0A5, srb = '0;
  int n, nval, nstb, nlow, run, lmin, lmax, bad, first, vcyc;
  logic p;

  snes_pad_reader #(.NUM_PADS(2), .NUM_BITS(8), .POLL_PERIOD(1000)) u_a (
    .clk(clk), .reset(rst_a), .en(en_a), .joy_data(data_a), .joy_strobe(js_a),
    .joy_clock(jc_a), .buttons(btn_a), .valid(val_a), .busy(busy_a));
  snes_pad_reader #(.POLL_PERIOD(100)) u_b (
    .clk(clk), .reset(rst_b), .en(en_b), .joy_data(data_b), .joy_strobe(js_b),
    .joy_clock(jc_b), .buttons(btn_b), .valid(val_b), .busy(busy_b));

  // Pad models: strobe loads the pressed pattern, each rising shift clock advances one bit.
  always @(posedge jc_a or posedge js_a)
    if (js_a) begin sr0 <= pat0; sr1 <= pat1; end
    else begin sr0 <= sr0 >> 1; sr1 <= sr1 >> 1; end
  always @(posedge jc_b or posedge js_b)
    if (js_b) srb <= pat_b;
    else srb <= srb >> 1;
  assign data_a = {~sr1[0], ~sr0[0]};
  assign data_b = ~srb[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_a_strobe", js_a, 0);
    check("rst_a_clock", jc_a, 1);
    check("rst_a_buttons", btn_a, 0);
    check("rst_a_valid", val_a, 0);
    check("rst_a_busy", busy_a, 0);
    check("rst_b_strobe", js_b, 0);
    check("rst_b_clock", jc_b, 1);
    check("rst_b_buttons", btn_b, 0);
    // Single 12-bit pad: frame shape and decode.
    rst_b = 1'b0; en_b = 1'b1;
    first = -1; vcyc = -1; nstb = 0; nlow = 0; run = 0; lmin = 999; lmax = 0; bad = 0;
    for (int i = 0; i < 400 && vcyc < 0; i++) begin
      @(negedge clk);
      if (js_b) begin nstb++; if (first < 0) first = i; end
      if (js_b && !jc_b) bad++;
      if (!jc_b) run++;
      else if (run > 0) begin
        nlow++; lmin = (run < lmin) ? run : lmin; lmax = (run > lmax) ? run : lmax; run = 0;
      end
      if (val_b) vcyc = i;
    end
    check("b_first_strobe", first, 0);
    check("b_strobe_width", nstb, 52);
    check("b_low_pulses", nlow, 12);
    check("b_low_min", lmin, 13);
    check("b_low_max", lmax, 13);
    check("b_strobe_clock_legal", bad, 0);
    check("b_valid_offset", vcyc - first, 364);
    check("b_buttons", btn_b, 12'h0A5);
    // POLL_PERIOD shorter than a frame: back-to-back frames with one idle cycle.
    @(negedge clk);
    check("b_valid_one_cycle", val_b, 0);
    check("b_idle_gap", js_b, 0);
    @(negedge clk);
    check("b_b2b_start", js_b, 1);
    pat_b = 12'h5C3;
    for (int k = 0; k < 2; k++) begin
      n = 0; nval = 0;
      do begin p = js_b; @(negedge clk); n++; nval += int'(val_b); end
      while (!(js_b && !p) && n < 1000);
      check("b_period", n, 366);
      check("b_valid_per_frame", nval, 1);
    end
    check("b_buttons2", btn_b, 12'h5C3);
    en_b = 1'b0;
    // Two 8-bit pads, enabled from reset.
    rst_a = 1'b0; en_a = 1'b1;
    @(negedge clk);
    check("a_start", js_a, 1);
    check("a_busy", busy_a, 1);
    n = 0;
    while (!val_a && n < 400) begin @(negedge clk); n++; end
    check("a_valid_offset", n, 260);
    check("a_buttons", btn_a, 16'h3C81);
    do begin p = js_a; @(negedge clk); n++; end while (!(js_a && !p) && n < 2000);
    check("a_next_start", n, 1000);
    // Reset in the middle of bit 5's low phase.
    repeat (187) @(negedge clk);
    check("a_in_bit5_low", jc_a, 0);
    #1 rst_a = 1'b1;
    #1;
    check("a_midrst_clock", jc_a, 1);
    check("a_midrst_strobe", js_a, 0);
    check("a_midrst_buttons", btn_a, 0);
    check("a_midrst_valid", val_a, 0);
    check("a_midrst_busy", busy_a, 0);
    en_a = 1'b0; pat0 = 8'h5A; pat1 = 8'hC3;
    @(negedge clk); rst_a = 1'b0;
    nstb = 0;
    for (int i = 0; i < 3000; i++) begin @(negedge clk); nstb += int'(js_a) + int'(busy_a); end
    check("a_en0_quiet", nstb, 0);
    en_a = 1'b1;
    @(negedge clk);
    check("a_en_start", js_a, 1);
    en_a = 1'b0;
    n = 0;
    while (!val_a && n < 400) begin @(negedge clk); n++; end
    check("a_en_drop_completes", n, 260);
    check("a_buttons_after_rst", btn_a, 16'hC35A);
    nstb = 0;
    for (int i = 0; i < 1100; i++) begin @(negedge clk); nstb += int'(js_a); end
    check("a_no_frame_en0", nstb, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
